// File: rtl/dmac_chan_ctrl_param_if.sv
// AHB-Lite master port plus channel FIFO side-band for one DMA channel.
// The master modport is the controller's view; the slave modport is the bus/FIFO side.
interface dmac_chan_ctrl_param_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hburst;
  logic              hready;
  logic [1:0]        hresp;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic              fifo_full;
  logic              fifo_empty;

  modport master (
    output haddr, htrans, hwrite, hburst, fifo_wr_en, fifo_rd_en,
    input  hready, hresp, fifo_full, fifo_empty
  );

  modport slave (
    input  haddr, htrans, hwrite, hburst, fifo_wr_en, fifo_rd_en,
    output hready, hresp, fifo_full, fifo_empty
  );
endinterface

// File: rtl/dmac_chan_ctrl_param.sv
// DMA channel controller: moves trans_size beats in chunks of up to burst_len beats,
// reading into the channel FIFO and then writing the chunk out over AHB-Lite.
module dmac_chan_ctrl_param #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  channel_en,
  input  logic                  abort,
  input  logic                  irq_clr,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [CNT_W-1:0]      trans_size,
  input  logic [CNT_W-1:0]      burst_len,
  dmac_chan_ctrl_param_if.master bus,
  output logic                  busy,
  output logic                  irq_done,
  output logic                  irq_err
);

  localparam logic [1:0]        HtIdle   = 2'b00;
  localparam logic [1:0]        HtBusy   = 2'b01;
  localparam logic [1:0]        HtNonseq = 2'b10;
  localparam logic [1:0]        HtSeq    = 2'b11;
  localparam logic [1:0]        HrespErr = 2'b01;
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ChunkMax = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] AddrInc  = ADDR_W'(BEAT_BYTES);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StPause, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d, chunk_q, chunk_d, beat_cnt_q, beat_cnt_d;
  logic              dphase_q, dphase_d, dphase_wr_q, dphase_wr_d;
  logic              first_q, first_d, ret_wr_q, ret_wr_d, abort_q, abort_d;
  logic              irq_done_q, irq_done_d, irq_err_q, irq_err_d;

  logic [CNT_W-1:0]  chunk_beats, burst_eff;
  logic [1:0]        htrans;
  logic              in_wr, err_det, dp_idle, issue, beat_acc;

  assign in_wr       = (state_q == StWr);
  assign chunk_beats = (chunk_q < remaining_q) ? chunk_q : remaining_q;
  assign burst_eff   = (burst_len == '0) ? CntOne : burst_len;
  // First ERROR cycle of a two-cycle response: the data phase is still stalled.
  assign err_det     = dphase_q & ~bus.hready & (bus.hresp == HrespErr);
  // No data phase will be outstanding after this cycle.
  assign dp_idle     = ~dphase_q | bus.hready;
  assign issue       = ((state_q == StRd) || (state_q == StWr)) && channel_en && !abort &&
                       !abort_q && !err_det && (beat_cnt_q < chunk_beats);

  always_comb begin
    htrans = HtIdle;
    if (issue) begin
      if (first_q) begin
        htrans = HtNonseq;
      end else if (in_wr ? bus.fifo_empty : bus.fifo_full) begin
        htrans = HtBusy;
      end else begin
        htrans = HtSeq;
      end
    end
  end

  assign beat_acc       = bus.hready & htrans[1];
  assign bus.htrans     = htrans;
  assign bus.hwrite     = in_wr;
  assign bus.hburst     = 3'b001;
  assign bus.haddr      = (state_q == StRd) ? src_ptr_q : (state_q == StWr) ? dst_ptr_q : '0;
  assign bus.fifo_wr_en = dphase_q & ~dphase_wr_q & bus.hready;
  assign bus.fifo_rd_en = beat_acc & in_wr;

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    chunk_d     = chunk_q;
    beat_cnt_d  = beat_cnt_q;
    dphase_d    = dphase_q & ~bus.hready;
    dphase_wr_d = dphase_wr_q;
    first_d     = first_q;
    ret_wr_d    = ret_wr_q;
    abort_d     = abort_q;

    if (beat_acc) begin
      beat_cnt_d  = beat_cnt_q + CntOne;
      first_d     = 1'b0;
      dphase_d    = 1'b1;
      dphase_wr_d = in_wr;
      if (in_wr) begin
        dst_ptr_d = dst_ptr_q + AddrInc;
      end else begin
        src_ptr_d = src_ptr_q + AddrInc;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_ptr_d   = src_addr;
          dst_ptr_d   = dst_addr;
          remaining_d = trans_size;
          chunk_d     = (burst_eff > ChunkMax) ? ChunkMax : burst_eff;
          beat_cnt_d  = '0;
          first_d     = 1'b1;
          abort_d     = 1'b0;
          state_d     = (trans_size == '0) ? StDone : StRd;
        end
      end
      StRd, StWr, StPause: begin
        if (err_det) begin
          state_d  = StErr;
          dphase_d = 1'b0;
          abort_d  = 1'b0;
        end else if (abort || abort_q) begin
          abort_d = 1'b1;
          if (dp_idle) begin
            state_d = StIdle;
            abort_d = 1'b0;
          end
        end else if (!channel_en && (state_q != StPause)) begin
          state_d  = StPause;
          ret_wr_d = in_wr;
        end else if (state_q == StPause) begin
          if (channel_en && dp_idle) begin
            state_d = ret_wr_q ? StWr : StRd;
            first_d = 1'b1;
          end
        end else if ((beat_cnt_q == chunk_beats) && dp_idle) begin
          beat_cnt_d = '0;
          first_d    = 1'b1;
          if (in_wr) begin
            remaining_d = remaining_q - beat_cnt_q;
            state_d     = (remaining_q == beat_cnt_q) ? StDone : StRd;
          end else begin
            state_d = StWr;
          end
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // Flags are raised on entry to DONE/ERR; a same-cycle clear takes priority.
  assign irq_done_d = irq_clr ? 1'b0 : (irq_done_q | (state_d == StDone));
  assign irq_err_d  = irq_clr ? 1'b0 : (irq_err_q | (state_d == StErr));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      beat_cnt_q  <= '0;
      dphase_q    <= 1'b0;
      dphase_wr_q <= 1'b0;
      first_q     <= 1'b0;
      ret_wr_q    <= 1'b0;
      abort_q     <= 1'b0;
      irq_done_q  <= 1'b0;
      irq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      chunk_q     <= chunk_d;
      beat_cnt_q  <= beat_cnt_d;
      dphase_q    <= dphase_d;
      dphase_wr_q <= dphase_wr_d;
      first_q     <= first_d;
      ret_wr_q    <= ret_wr_d;
      abort_q     <= abort_d;
      irq_done_q  <= irq_done_d;
      irq_err_q   <= irq_err_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign irq_done = irq_done_q;
  assign irq_err  = irq_err_q;

endmodule

// File: tb/tb_dmac_chan_ctrl_param.sv
// Bench for dmac_chan_ctrl_param: a chunk-level transfer model fills a queue of expected
// bus beats which a negedge monitor pops and compares whenever an AHB beat is accepted.
module tb_dmac_chan_ctrl_param;
  localparam int unsigned ADDR_W = 32, CNT_W = 16, BEAT_BYTES = 4, FIFO_DEPTH = 16;
  localparam logic [1:0] HtIdle = 2'b00, HtBusy = 2'b01, HtNonseq = 2'b10, HtSeq = 2'b11;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              first;
  } beat_t;

  beat_t exp_q[$];

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, channel_en = 1'b1, abort = 1'b0, irq_clr = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0, dst_addr = '0;
  logic [CNT_W-1:0]  trans_size = '0, burst_len = '0;
  logic busy, irq_done, irq_err;
  int   checks = 0, errors = 0, rd_acc = 0, wr_acc = 0, pushes = 0, pops = 0;
  bit   pause_seen = 1'b0, rand_on = 1'b0;

  dmac_chan_ctrl_param_if #(.ADDR_W(ADDR_W)) bus ();

  dmac_chan_ctrl_param #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BEAT_BYTES(BEAT_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .channel_en(channel_en), .abort(abort),
    .irq_clr(irq_clr), .src_addr(src_addr), .dst_addr(dst_addr), .trans_size(trans_size),
    .burst_len(burst_len), .bus(bus), .busy(busy), .irq_done(irq_done), .irq_err(irq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: chunk = clamp(burst_len, 1, FIFO_DEPTH); each chunk reads n beats then writes n.
  task automatic push_model(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input int size, input int blen);
    int    chunk;
    int    rem;
    int    n;
    beat_t b;
    chunk = (blen == 0) ? 1 : blen;
    if (chunk > int'(FIFO_DEPTH)) chunk = int'(FIFO_DEPTH);
    rem = size;
    while (rem > 0) begin
      n = (rem < chunk) ? rem : chunk;
      for (int i = 0; i < n; i++) begin
        b.addr = s + ADDR_W'(i * BEAT_BYTES); b.wr = 1'b0; b.first = (i == 0);
        exp_q.push_back(b);
      end
      for (int i = 0; i < n; i++) begin
        b.addr = d + ADDR_W'(i * BEAT_BYTES); b.wr = 1'b1; b.first = (i == 0);
        exp_q.push_back(b);
      end
      s   = s + ADDR_W'(n * BEAT_BYTES);
      d   = d + ADDR_W'(n * BEAT_BYTES);
      rem = rem - n;
    end
  endtask

  // Monitor: every accepted NONSEQ/SEQ beat must be the next expected one.
  always @(negedge clk) begin
    beat_t      e;
    logic [1:0] kind;
    if (!rst) begin
      if (bus.hready && (bus.htrans == HtNonseq || bus.htrans == HtSeq)) begin
        if (exp_q.size() == 0) begin
          check("extra_beat_htrans", {62'd0, bus.htrans}, 64'd0);
        end else begin
          e    = exp_q.pop_front();
          kind = (e.first || pause_seen) ? HtNonseq : HtSeq;
          check("beat_addr", bus.haddr, e.addr);
          check("beat_hwrite", bus.hwrite, e.wr);
          check("beat_htrans", bus.htrans, kind);
          check("beat_fifo_rd_en", bus.fifo_rd_en, e.wr);
        end
        if (bus.hwrite) wr_acc++; else rd_acc++;
        pause_seen = 1'b0;
      end
      if (busy && !channel_en) pause_seen = 1'b1;
      if (bus.fifo_wr_en) pushes++;
      if (bus.fifo_rd_en) pops++;
    end
  end

  // Random slave wait states, FIFO stalls and channel pauses.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_on) begin
        bus.hready     = ($urandom_range(0, 3) != 0);
        bus.fifo_full  = ($urandom_range(0, 4) == 0);
        bus.fifo_empty = ($urandom_range(0, 4) == 0);
        channel_en     = ($urandom_range(0, 11) != 0);
      end
    end
  end

  task automatic run_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input int size, input int blen);
    exp_q.delete();
    push_model(s, d, size, blen);
    rd_acc = 0; wr_acc = 0; pushes = 0; pops = 0; pause_seen = 1'b0;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; trans_size = CNT_W'(size); burst_len = CNT_W'(blen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_busy_timeout"}, busy, 0);
  endtask

  task automatic wait_acc(input bit wr, input int n, input string name);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (((wr ? wr_acc : rd_acc) < n) && k < 500);
    check({name, "_reached"}, ((wr ? wr_acc : rd_acc) >= n), 1);
  endtask

  task automatic finish_xfer(input string name, input bit exp_done, input int exp_push,
                             input int exp_pop);
    wait_idle(name, 4000);
    check({name, "_leftover_beats"}, exp_q.size(), 0);
    check({name, "_irq_done"}, irq_done, exp_done);
    check({name, "_pushes"}, pushes, exp_push);
    check({name, "_pops"}, pops, exp_pop);
  endtask

  task automatic clear_irq(input string name);
    @(posedge clk); #1; irq_clr = 1'b1;
    @(posedge clk); #1; irq_clr = 1'b0;
    @(negedge clk);
    check({name, "_irq_done_clr"}, irq_done, 0);
    check({name, "_irq_err_clr"}, irq_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int nb;
    int k;
    bit nonidle;
    int size;
    int blen;
    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] d;

    bus.hready = 1'b1; bus.hresp = 2'b00; bus.fifo_full = 1'b0; bus.fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_htrans", bus.htrans, HtIdle);
    check("rst_haddr", bus.haddr, 0);
    check("rst_hwrite", bus.hwrite, 0);
    check("rst_hburst", bus.hburst, 3'b001);
    check("rst_fifo_wr_en", bus.fifo_wr_en, 0);
    check("rst_fifo_rd_en", bus.fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", {irq_done, irq_err}, 0);

    // Basic two-chunk transfer.
    run_start(32'h100, 32'h200, 6, 4);
    finish_xfer("basic", 1'b1, 6, 6);
    clear_irq("basic");

    // Zero-size transfer: no bus activity, short busy pulse.
    run_start(32'h0, 32'h0, 0, 4);
    nb = 0; nonidle = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) nb++;
      if (bus.htrans != HtIdle) nonidle = 1'b1;
    end
    check("zero_busy_1to2_cycles", (nb >= 1 && nb <= 2), 1);
    check("zero_htrans_idle", nonidle, 0);
    check("zero_irq_done", irq_done, 1);
    clear_irq("zero");

    // Wait states: third read beat held while hready is low.
    run_start(32'h1000, 32'h2000, 4, 4);
    wait_acc(1'b0, 2, "ws_rd2");
    #1 bus.hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ws_haddr_held", bus.haddr, 32'h1008);
      check("ws_htrans_held", bus.htrans, HtSeq);
    end
    @(posedge clk); #1 bus.hready = 1'b1;
    finish_xfer("ws", 1'b1, 4, 4);
    clear_irq("ws");

    // Pause after two read beats, then resume with NONSEQ at the next address.
    run_start(32'h3000, 32'h4000, 6, 6);
    wait_acc(1'b0, 2, "pause_rd2");
    #1 channel_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pause_htrans_idle", bus.htrans, HtIdle);
    end
    @(posedge clk); #1 channel_en = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.htrans == HtIdle && k < 8);
    check("resume_htrans", bus.htrans, HtNonseq);
    check("resume_haddr", bus.haddr, 32'h3008);
    finish_xfer("pause", 1'b1, 6, 6);
    clear_irq("pause");

    // Bus error on the data phase of the third write beat.
    run_start(32'h5000, 32'h6000, 8, 4);
    wait_acc(1'b1, 3, "err_wr3");
    #1 bus.hready = 1'b0; bus.hresp = 2'b01;
    @(posedge clk); #1 bus.hready = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 bus.hresp = 2'b00;
    finish_xfer("err", 1'b0, 4, 3);
    check("err_irq_err", irq_err, 1);
    repeat (4) @(negedge clk);
    check("err_no_more_beats", rd_acc + wr_acc, 7);
    clear_irq("err");

    // Reset in the middle of a write chunk.
    run_start(32'h7000, 32'h8000, 8, 8);
    wait_acc(1'b1, 2, "rst_wr2");
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_htrans", bus.htrans, HtIdle);
    check("midrst_haddr", bus.haddr, 0);
    check("midrst_hwrite", bus.hwrite, 0);
    check("midrst_fifo_en", {bus.fifo_wr_en, bus.fifo_rd_en}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_irq", {irq_done, irq_err}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Abort mid-read: the outstanding data phase still pushes, no interrupt.
    run_start(32'h9000, 32'hA000, 8, 8);
    wait_acc(1'b0, 3, "abort_rd3");
    #1 abort = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle_next", busy, 0);
    finish_xfer("abort", 1'b0, 3, 0);
    check("abort_irq_err", irq_err, 0);

    // FIFO full during a read chunk: BUSY after the NONSEQ, then SEQ once released.
    bus.fifo_full = 1'b1;
    run_start(32'hB000, 32'hC000, 4, 4);
    wait_acc(1'b0, 1, "bp_rd1");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_htrans_busy", bus.htrans, HtBusy);
      check("bp_haddr", bus.haddr, 32'hB004);
    end
    check("bp_pushes_stalled", pushes, 1);
    @(posedge clk); #1 bus.fifo_full = 1'b0;
    finish_xfer("bp", 1'b1, 4, 4);
    clear_irq("bp");

    // burst_len above FIFO depth clamps to 16; source pointer wraps past 2^32.
    run_start(32'hFFFF_FFC0, 32'h100, 20, 32);
    finish_xfer("clamp", 1'b1, 20, 20);
    clear_irq("clamp");

    // Randomised transfers with wait states, FIFO stalls and pauses.
    rand_on = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom & 32'hFFFF_FFFC;
      size = $urandom_range(1, 40);
      blen = $urandom_range(0, 20);
      run_start(s, d, size, blen);
      finish_xfer("rand", 1'b1, size, size);
      clear_irq("rand");
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    bus.hready = 1'b1; bus.fifo_full = 1'b0; bus.fifo_empty = 1'b0; channel_en = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
